depth_engine: RTL and testbench
===============================

// Module: depth_engine
// PURPOSE
// Parametrised Mandelbrot escape-depth engine for one pixel at a time. Successor to the fixed-width depth block.
// Adds valid/ready on input and output, a run-time max_iter, a pixel-coordinate tag passthrough and an escaped flag.
// Sits between the pixel/coordinate generator (which supplies c plus x,y) and the colour mapper / frame writer.
// PARAMETERS
// DW      32  signed fixed-point word width of c and z (Q(DW-FRAC).FRAC)
// FRAC    16  fractional bits; must satisfy 2 <= FRAC <= DW-4
// ITER_W  10  width of max_iter and depth
// XW      10  x tag width
// YW       9  y tag width
// PORTS
// sysclk     in   1       clock; all logic on posedge
// reset      in   1       synchronous, active-high
// in_valid   in   1       request present
// in_ready   out  1       engine can accept (high only in IDLE)
// in_re_c    in   DW      real part of c, signed Q format
// in_im_c    in   DW      imaginary part of c, signed Q format
// in_x       in   XW      pixel x tag
// in_y       in   YW      pixel y tag
// max_iter   in   ITER_W  iteration limit, sampled at accept
// out_valid  out  1       result present; held until out_ready
// out_ready  in   1       consumer takes result
// out_depth  out  ITER_W  completed iterations at termination
// out_esc    out  1       1 = |z|^2 > 4 terminated; 0 = max_iter reached
// out_x      out  XW      tag of the result
// out_y      out  YW      tag of the result
// BEHAVIOUR
// - Reset (sync): state=IDLE; out_valid=0, out_depth=0, out_esc=0, out_x=0, out_y=0; in_ready=0 while reset high.
//   Reset mid-iteration aborts the pixel; no result is emitted.
// - States: IDLE -> ITER -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready, latch c, x, y and max_iter. Set z=0, depth=0. Go to ITER.
//   ITER: one iteration per cycle, evaluated on the current z:
//     - if esc(z): out_depth=depth, out_esc=1 -> DONE
//     - elif depth==max_iter_latched: out_depth=depth, out_esc=0 -> DONE
//     - else: z <= z^2+c, depth <= depth+1
//   DONE: out_valid=1. out_* stable until out_valid&&out_ready, then -> IDLE.
// - Timing and throughput:
//   - Accept on edge 0 -> out_valid high after edge d+1, where d = out_depth.
//   - in_ready is low from the accept edge until the cycle after the output handshake, so per-pixel occupancy is d+3 cycles.
//   - out_ready may be high before out_valid; the handshake then completes in the first out_valid cycle.
//   - in_valid while busy is ignored (no accept).
// - Arithmetic:
//   - Products rr=re*re, ii=im*im, ri=re*im are full 2*DW signed.
//   - esc(z) = (rr+ii) > (4 << 2*FRAC). The sum is computed in 2*DW+1 bits, so there is no overflow in the test.
//   - Next-z crop is [DW+FRAC-1 -: DW] (two's-complement truncation):
//     - re' = crop(rr) - crop(ii) + re_c
//     - im' = crop(ri<<<1) + im_c
//   - Because esc is checked before each update, |z| <= 2 always holds before an update. No saturation is needed provided |c| < 2^(DW-FRAC-1)-8.
// - Boundaries:
//   - max_iter=0: result depth 0, out_esc=0 after edge 1.
//   - max_iter=2^ITER_W-1: depth never wraps, because the compare happens before the increment.
//   - esc and depth==max_iter in the same cycle: esc wins, out_esc=1.
// STRUCTURE
// - Package mandel_pkg holds:
//   - typedef enum logic [1:0] {IDLE, ITER, DONE} depth_state_t
//   - function esc_threshold(DW, FRAC)
//   - default DW/FRAC/ITER_W localparams shared with the coordinate generator
// - Sub-module depth_step (combinational):
//   - inputs z, c
//   - outputs z_next and esc
//   - holds all multipliers; it is the natural place to pipeline the step later.
// - depth_engine holds the FSM, the latches and the output register.
// TESTING (DW=32, FRAC=16, 1.0 = 0x0001_0000)
// 1 c=(0,0), max_iter=10 -> out_depth=10, out_esc=0, out_valid after edge 11.
// 2 c=(1.0,0) -> z: 0,1,2,5 (|z|^2 of 4 does not escape) -> out_depth=3, out_esc=1.
//   c=(2.0,0) -> out_depth=2, out_esc=1.
// 3 c=(-2.0,0), max_iter=50 -> z fixed at 2 (|z|^2==4, no escape) -> out_depth=50, out_esc=0.
//   max_iter=0 -> out_depth=0.
// 4 x=639, y=479, out_ready low 5 cycles after out_valid:
//   - outputs stable and in_ready=0 throughout
//   - after out_ready the tag reads 639/479
//   - next request accepted exactly one cycle after the handshake
// 5 reset asserted at depth 4 of a max_iter=100 pixel -> next edge: out_valid=0, in_ready=0.
//   After reset release: in_ready=1, and a fresh c=(0,0) pixel returns depth 100.

Source files
------------

// File: rtl/mandel_pkg.sv
// mandel_pkg: shared FSM states, default widths and escape threshold for the Mandelbrot depth path
package mandel_pkg;
  typedef enum logic [1:0] {IDLE, ITER, DONE} depth_state_t;
  localparam int DW_DEF = 32;
  localparam int FRAC_DEF = 16;
  localparam int ITER_W_DEF = 10;
  function automatic logic [255:0] esc_threshold(input int dw, input int frac);
    return (256'(4) << (2 * frac)) & ((256'(1) << (2 * dw + 1)) - 256'(1));
  endfunction
endpackage

// File: rtl/depth_step.sv
// depth_step: one combinational z <= z^2 + c step with the |z|^2 > 4 escape test
module depth_step
  import mandel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  input  logic signed [DW-1:0] re_c,
  input  logic signed [DW-1:0] im_c,
  output logic signed [DW-1:0] re_next,
  output logic signed [DW-1:0] im_next,
  output logic                 esc
);
  localparam logic signed [2*DW:0] THR = (2*DW+1)'(esc_threshold(DW, FRAC));
  logic signed [2*DW-1:0] rr, ii, ri;
  logic signed [2*DW:0] mag;
  assign rr = (2*DW)'(re) * (2*DW)'(re);
  assign ii = (2*DW)'(im) * (2*DW)'(im);
  assign ri = (2*DW)'(re) * (2*DW)'(im);
  assign mag = (2*DW+1)'(rr) + (2*DW+1)'(ii);
  assign esc = mag > THR;
  // shifting ri by FRAC-1 instead of FRAC folds in the factor 2 of 2*re*im
  assign re_next = DW'(rr >>> FRAC) - DW'(ii >>> FRAC) + re_c;
  assign im_next = DW'(ri >>> (FRAC - 1)) + im_c;
endmodule

// File: rtl/depth_engine.sv
// depth_engine: per-pixel Mandelbrot escape depth with valid/ready handshakes and tag passthrough
module depth_engine
  import mandel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int ITER_W = ITER_W_DEF,
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re_c,
  input  logic signed [DW-1:0] in_im_c,
  input  logic [XW-1:0]        in_x,
  input  logic [YW-1:0]        in_y,
  input  logic [ITER_W-1:0]    max_iter,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ITER_W-1:0]    out_depth,
  output logic                 out_esc,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y
);
  depth_state_t state, state_next;
  logic signed [DW-1:0] re, im, re_c, im_c, re_next, im_next;
  logic [ITER_W-1:0] depth, lim;
  logic esc, fin, accept;
  depth_step #(.DW(DW), .FRAC(FRAC)) u_step (
    .re(re), .im(im), .re_c(re_c), .im_c(im_c),
    .re_next(re_next), .im_next(im_next), .esc(esc)
  );
  always_comb begin
    in_ready = (state == IDLE) && !reset;
    out_valid = state == DONE;
    accept = in_valid && in_ready;
    fin = esc || (depth == lim);
    state_next = (state == IDLE) ? (in_valid ? ITER : IDLE) :
                 (state == ITER) ? (fin ? DONE : ITER) :
                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      out_depth <= '0;
      out_esc <= 1'b0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        re <= '0;
        im <= '0;
        re_c <= in_re_c;
        im_c <= in_im_c;
        depth <= '0;
        lim <= max_iter;
        out_x <= in_x;
        out_y <= in_y;
      end else if (state == ITER) begin
        // escape is tested before the limit so it wins a tie, and depth never wraps
        if (fin) begin
          out_depth <= depth;
          out_esc <= esc;
        end else begin
          re <= re_next;
          im <= im_next;
          depth <= depth + ITER_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_depth_engine.sv
// tb_depth_engine: directed checks of depth, escape flag, latency, tags, backpressure and reset abort
module tb_depth_engine;
  localparam int DW = 32, FRAC = 16, ITER_W = 10, XW = 10, YW = 9;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] TWO = 32'h0002_0000;
  localparam logic [31:0] MTWO = 32'hFFFE_0000;
  logic sysclk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_esc;
  logic signed [DW-1:0] in_re_c = '0, in_im_c = '0;
  logic [XW-1:0] in_x = '0, out_x;
  logic [YW-1:0] in_y = '0, out_y;
  logic [ITER_W-1:0] max_iter = '0, out_depth;
  int checks = 0, errors = 0;

  depth_engine #(.DW(DW), .FRAC(FRAC), .ITER_W(ITER_W), .XW(XW), .YW(YW)) dut (
    .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_re_c(in_re_c), .in_im_c(in_im_c), .in_x(in_x), .in_y(in_y), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth), .out_esc(out_esc),
    .out_x(out_x), .out_y(out_y)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] re, input logic [31:0] im, input int x, input int y,
                         input int mi);
    in_re_c = re;
    in_im_c = im;
    in_x = XW'(x);
    in_y = YW'(y);
    max_iter = ITER_W'(mi);
    in_valid = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int d);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 2000);
    check({tag, " latency"}, n, d + 1);
  endtask

  task automatic run(input string tag, input logic [31:0] re, input logic [31:0] im, input int x,
                     input int y, input int mi, input int d, input logic e);
    check({tag, " ready"}, in_ready, 1);
    set_req(re, im, x, y, mi);
    tick();
    in_valid = 1'b0;
    check({tag, " busy"}, in_ready, 0);
    wait_valid(tag, d);
    check({tag, " depth"}, out_depth, d);
    check({tag, " esc"}, out_esc, e);
    check({tag, " x"}, out_x, x);
    check({tag, " y"}, out_y, y);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " released"}, out_valid, 0);
    check({tag, " idle"}, in_ready, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst valid", out_valid, 0);
    check("rst depth", out_depth, 0);
    check("rst esc", out_esc, 0);
    check("rst x", out_x, 0);
    check("rst y", out_y, 0);
    check("rst ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("post rst ready", in_ready, 1);

    run("c0 mi10", 32'h0, 32'h0, 1, 2, 10, 10, 1'b0);
    run("c1", ONE, 32'h0, 3, 4, 10, 3, 1'b1);
    run("c2", TWO, 32'h0, 5, 6, 10, 2, 1'b1);
    run("cm2", MTWO, 32'h0, 7, 8, 50, 50, 1'b0);
    run("mi0", MTWO, 32'h0, 9, 10, 0, 0, 1'b0);
    run("tie", ONE, 32'h0, 11, 12, 3, 3, 1'b1);
    run("im c", 32'h0, TWO, 13, 14, 20, 2, 1'b1);
    run("mi max", 32'h0, 32'h0, 15, 16, 1023, 1023, 1'b0);

    // backpressure with a competing request held on the input
    set_req(ONE, 32'h0, 639, 479, 10);
    tick();
    set_req(32'h0, 32'h0, 20, 21, 0);
    wait_valid("bp", 3);
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", out_valid, 1);
      check("bp hold depth", out_depth, 3);
      check("bp hold esc", out_esc, 1);
      check("bp hold ready", in_ready, 0);
      check("bp hold x", out_x, 639);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp tag x", out_x, 639);
    check("bp tag y", out_y, 479);
    check("bp ready after hs", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp next accepted", in_ready, 0);
    check("bp next tag", out_x, 20);
    tick();
    check("bp next valid", out_valid, 1);
    check("bp next depth", out_depth, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset aborts a pixel mid-iteration
    set_req(32'h0, 32'h0, 30, 31, 100);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("abort valid", out_valid, 0);
    check("abort ready", in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("abort released ready", in_ready, 1);
    repeat (3) tick();
    check("abort no result", out_valid, 0);
    run("after abort", 32'h0, 32'h0, 32, 33, 100, 100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
